// File: rtl/vga_draw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_draw_pkg
// Description : Screen geometry, default box size, requester indices and FSM
//               state encoding shared by the VGA draw arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_draw_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int DEF_BOX_W = 4;
    localparam int DEF_BOX_H = 3;

    localparam logic [1:0] REQ_BOARD = 2'd0;
    localparam logic [1:0] REQ_P1    = 2'd1;
    localparam logic [1:0] REQ_P2    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/draw_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : draw_req_arbiter
// Description : Fixed priority for the board sequencer, round-robin between
//               the two players; pointer advances only when a box completes.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_req_arbiter
    import vga_draw_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       served_valid,
    input  logic [1:0] served_idx,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    // High when player two should win the next player tie.
    logic r_prefer_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prefer_p2 <= 1'b0;
        end else if (served_valid) begin
            if (served_idx == REQ_P1) begin
                r_prefer_p2 <= 1'b1;
            end else if (served_idx == REQ_P2) begin
                r_prefer_p2 <= 1'b0;
            end
        end
    end

    always_comb begin
        grant_valid = |req;
        grant_idx   = REQ_BOARD;
        if (req[0]) begin
            grant_idx = REQ_BOARD;
        end else if (req[1] && req[2]) begin
            grant_idx = r_prefer_p2 ? REQ_P2 : REQ_P1;
        end else if (req[1]) begin
            grant_idx = REQ_P1;
        end else if (req[2]) begin
            grant_idx = REQ_P2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_draw_arbiter
// Description : Grants one of three requesters and rasters its BOX_W x BOX_H
//               box to the VGA adapter, one pixel per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int BOX_W = DEF_BOX_W,
    parameter int BOX_H = DEF_BOX_H
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [20:0] req_y,
    input  logic [8:0]  req_colour,
    output logic [2:0]  done,
    output logic        busy,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    localparam logic [2:0] c_last_cx = 3'(BOX_W - 1);
    localparam logic [2:0] c_last_cy = 3'(BOX_H - 1);

    draw_state_t r_state, w_next_state;

    logic       w_grant_valid;
    logic [1:0] w_grant_idx;
    logic [7:0] w_sel_x;
    logic [6:0] w_sel_y;
    logic [2:0] w_sel_colour;

    logic [1:0] r_winner;
    logic [7:0] r_base_x;
    logic [6:0] r_base_y;
    logic [2:0] r_colour;
    logic [2:0] r_cx, r_cy;
    logic [7:0] r_hold_x;
    logic [6:0] r_hold_y;
    logic [2:0] r_hold_colour;

    logic [7:0] w_pix_x;
    logic [6:0] w_pix_y;
    logic       w_last_cx, w_last_cy, w_on_screen, w_drawing, w_finishing;

    draw_req_arbiter u_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .served_valid (w_finishing),
        .served_idx   (r_winner),
        .grant_valid  (w_grant_valid),
        .grant_idx    (w_grant_idx)
    );

    always_comb begin
        w_sel_x      = req_x[7:0];
        w_sel_y      = req_y[6:0];
        w_sel_colour = req_colour[2:0];
        case (w_grant_idx)
            REQ_P1: begin
                w_sel_x      = req_x[15:8];
                w_sel_y      = req_y[13:7];
                w_sel_colour = req_colour[5:3];
            end
            REQ_P2: begin
                w_sel_x      = req_x[23:16];
                w_sel_y      = req_y[20:14];
                w_sel_colour = req_colour[8:6];
            end
            default: ;
        endcase
    end

    // Coordinates wrap naturally at 8/7 bits.
    assign w_pix_x     = r_base_x + {5'd0, r_cx};
    assign w_pix_y     = r_base_y + {4'd0, r_cy};
    assign w_last_cx   = (r_cx == c_last_cx);
    assign w_last_cy   = (r_cy == c_last_cy);
    assign w_on_screen = (w_pix_x < 8'(SCREEN_W)) && (w_pix_y < 7'(SCREEN_H));
    assign w_drawing   = (r_state == ST_DRAW);
    assign w_finishing = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_valid) w_next_state = ST_DRAW;
            ST_DRAW: if (w_last_cx && w_last_cy) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner      <= REQ_BOARD;
            r_base_x      <= 8'd0;
            r_base_y      <= 7'd0;
            r_colour      <= 3'd0;
            r_cx          <= 3'd0;
            r_cy          <= 3'd0;
            r_hold_x      <= 8'd0;
            r_hold_y      <= 7'd0;
            r_hold_colour <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_winner <= w_grant_idx;
                        r_base_x <= w_sel_x;
                        r_base_y <= w_sel_y;
                        r_colour <= w_sel_colour;
                        r_cx     <= 3'd0;
                        r_cy     <= 3'd0;
                    end
                end
                ST_DRAW: begin
                    // Off-screen pixels still update the held values.
                    r_hold_x      <= w_pix_x;
                    r_hold_y      <= w_pix_y;
                    r_hold_colour <= r_colour;
                    if (w_last_cx) begin
                        r_cx <= 3'd0;
                        if (!w_last_cy) r_cy <= r_cy + 3'd1;
                    end else begin
                        r_cx <= r_cx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign vga_plot   = w_drawing && w_on_screen;
    assign vga_x      = w_drawing ? w_pix_x  : r_hold_x;
    assign vga_y      = w_drawing ? w_pix_y  : r_hold_y;
    assign vga_colour = w_drawing ? r_colour : r_hold_colour;
    assign done[0]    = w_finishing && (r_winner == REQ_BOARD);
    assign done[1]    = w_finishing && (r_winner == REQ_P1);
    assign done[2]    = w_finishing && (r_winner == REQ_P2);

endmodule
`default_nettype wire

// File: doc/vga_draw_arbiter.md
VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 Parameter BOX_W, default 4, box width in pixels (1..8).
REQ-002 Parameter BOX_H, default 3, box height in pixels (1..8).
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  3  draw request per requester: [0] board-reset sequencer, [1] player one, [2] player two.
REQ-006 req_x  in  3x8  top-left box x per requester.
REQ-007 req_y  in  3x7  top-left box y per requester.
REQ-008 req_colour  in  3x3  box colour per requester.
REQ-009 done  out  3  one-cycle completion pulse per requester.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 vga_x  out  8  pixel x to the VGA adapter.
REQ-012 vga_y  out  7  pixel y to the VGA adapter.
REQ-013 vga_colour  out  3  pixel colour to the VGA adapter.
REQ-014 vga_plot  out  1  pixel write enable to the VGA adapter.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-016 In IDLE with any req bit high, the block SHALL pick a winner, latch that requester's x/y/colour, clear cx/cy and enter DRAW on the next edge.
REQ-017 Requester 0 SHALL always win over requesters 1 and 2.
REQ-018 Between requesters 1 and 2, the requester not served last SHALL win when both are high; the pointer SHALL update on DONE only.
REQ-019 In DRAW, vga_plot SHALL be 1, vga_x SHALL equal base_x+cx (mod 256), vga_y SHALL equal base_y+cy (mod 128), and vga_colour SHALL equal the latched colour.
REQ-020 cx SHALL increment each DRAW cycle and wrap to 0 after BOX_W-1, incrementing cy on wrap; raster order SHALL be row-major.
REQ-021 At cx=BOX_W-1, cy=BOX_H-1, the FSM SHALL enter DONE.
REQ-022 Any DRAW pixel with vga_x>=160 or vga_y>=120 SHALL have vga_plot=0 but still consume its cycle.
REQ-023 In DONE, done[winner] SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-024 Latency SHALL be fixed: req seen in IDLE at cycle 0 gives first plot at cycle 1, last plot at cycle BOX_W*BOX_H, and done at cycle BOX_W*BOX_H+1.
REQ-025 Inputs SHALL be latched only at grant; changes to req_x/req_y/req_colour during DRAW SHALL have no effect.
REQ-026 A requester SHALL drop req in the cycle after its done; a req still high in IDLE SHALL be a new request.
REQ-027 Outside DRAW, vga_plot SHALL be 0 and vga_x/vga_y/vga_colour SHALL hold their last values.
REQ-028 Requests arriving during DRAW/DONE SHALL wait; none SHALL be lost while req is held.

Reset
REQ-029 On reset, the block SHALL set state=IDLE, cx=cy=0, done=0, vga_plot=0, busy=0, vga_x=0, vga_y=0, vga_colour=0, and the round-robin pointer so player one wins the first tie.
REQ-030 Reset during DRAW SHALL abort the box with no done pulse, and no pixel SHALL be plotted in the reset cycle's successor.

Structure
REQ-031 Package vga_draw_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, the default BOX_W/BOX_H, the requester index constants and the FSM state type.
REQ-032 Winner selection and the round-robin pointer SHALL live in one sub-module, draw_req_arbiter; the counters, FSM and VGA outputs SHALL stay in the top module.

Verification
REQ-033 req[1] with (38,4), colour 3'b010, default box -> plots (38..41, 4..6) row-major in cycles 1-12; done[1] at cycle 13, and nowhere else.
REQ-034 req[1] and req[2] both held, each redrawing on done -> grants alternate 1,2,1,2; done pulses alternate.
REQ-035 req[0] (118,97, colour 3'b111) and req[2] raised together, with req[1] high -> requester 0 is served first, then requester 1 (pointer at reset), then requester 2.
REQ-036 req[2] with (158,118) -> only (158,118),(159,118),(158,119),(159,119) have vga_plot=1; done still at cycle 13.
REQ-037 Reset asserted at cycle 5 of a draw -> vga_plot=0 and busy=0 from the next cycle, no done pulse, and a held req is regranted afterward with the full 12 pixels.
REQ-038 req_x changed during DRAW -> all 12 pixels still use the latched base.
